// File: rtl/mem_req_demux.sv
// Registered 1-to-2 request router: steers each CPU data-memory request to data memory
// (port 0) or MMIO space (port 1) through a one-entry holding slot per port.
module mem_req_demux #(
    parameter int              AW        = 32,
    parameter int              DW        = 32,
    parameter logic [AW-1:0]   MMIO_BASE = 32'h0000_8000,
    parameter int              CW        = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_wdata,
    input  logic          in_we,

    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [AW-1:0] out0_addr,
    output logic [DW-1:0] out0_wdata,
    output logic          out0_we,

    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [AW-1:0] out1_addr,
    output logic [DW-1:0] out1_wdata,
    output logic          out1_we,

    output logic          misalign,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic          slot_valid_q [2];
    logic          slot_valid_d [2];
    logic [AW-1:0] slot_addr_q  [2];
    logic [AW-1:0] slot_addr_d  [2];
    logic [DW-1:0] slot_wdata_q [2];
    logic [DW-1:0] slot_wdata_d [2];
    logic          slot_we_q    [2];
    logic          slot_we_d    [2];
    logic [CW-1:0] cnt_q        [2];
    logic [CW-1:0] cnt_d        [2];

    logic          misalign_q;
    logic          misalign_d;

    logic          slot_ready [2];
    logic          drain      [2];
    logic          slot_free  [2];
    logic          tgt;
    logic          accept;

    assign slot_ready[0] = out0_ready;
    assign slot_ready[1] = out1_ready;

    assign tgt = (in_addr >= MMIO_BASE);

    // Both slots must be empty or draining: the target needs room, and the other port
    // must be clear so requests never overtake each other across ports.
    assign in_ready = ~rst & slot_free[0] & slot_free[1];
    assign accept   = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            localparam logic PORT = 1'(gi);

            assign drain[gi]     = slot_valid_q[gi] & slot_ready[gi];
            assign slot_free[gi] = ~slot_valid_q[gi] | drain[gi];

            always_comb begin
                slot_valid_d[gi] = slot_valid_q[gi];
                slot_addr_d[gi]  = slot_addr_q[gi];
                slot_wdata_d[gi] = slot_wdata_q[gi];
                slot_we_d[gi]    = slot_we_q[gi];
                cnt_d[gi]        = cnt_q[gi];

                if (accept && (tgt == PORT)) begin
                    slot_valid_d[gi] = 1'b1;
                    slot_addr_d[gi]  = in_addr;
                    slot_wdata_d[gi] = in_wdata;
                    slot_we_d[gi]    = in_we;
                    if (cnt_q[gi] != {CW{1'b1}}) begin
                        cnt_d[gi] = cnt_q[gi] + CW'(1);
                    end
                end else if (drain[gi]) begin
                    // Fields are left as-is once the slave has taken the request.
                    slot_valid_d[gi] = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_valid_q[gi] <= 1'b0;
                    slot_addr_q[gi]  <= '0;
                    slot_wdata_q[gi] <= '0;
                    slot_we_q[gi]    <= 1'b0;
                    cnt_q[gi]        <= '0;
                end else begin
                    slot_valid_q[gi] <= slot_valid_d[gi];
                    slot_addr_q[gi]  <= slot_addr_d[gi];
                    slot_wdata_q[gi] <= slot_wdata_d[gi];
                    slot_we_q[gi]    <= slot_we_d[gi];
                    cnt_q[gi]        <= cnt_d[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        misalign_d = misalign_q;
        if (accept && (in_addr[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign out0_valid = slot_valid_q[0];
    assign out0_addr  = slot_addr_q[0];
    assign out0_wdata = slot_wdata_q[0];
    assign out0_we    = slot_we_q[0];

    assign out1_valid = slot_valid_q[1];
    assign out1_addr  = slot_addr_q[1];
    assign out1_wdata = slot_wdata_q[1];
    assign out1_we    = slot_we_q[1];

    assign misalign = misalign_q;
    assign cnt0     = cnt_q[0];
    assign cnt1     = cnt_q[1];

endmodule

// File: tb/tb_mem_req_demux.sv
// Scoreboard bench for mem_req_demux: stimulus pushes expected requests per port,
// a forked monitor pops and compares on every output handshake.
module tb_mem_req_demux;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_we;
    logic [AW-1:0] in_addr;
    logic [DW-1:0] in_wdata;
    logic          out0_valid, out0_ready, out0_we;
    logic          out1_valid, out1_ready, out1_we;
    logic [AW-1:0] out0_addr, out1_addr;
    logic [DW-1:0] out0_wdata, out1_wdata;
    logic          misalign;
    logic [CW-1:0] cnt0, cnt1;

    mem_req_demux #(.AW(AW), .DW(DW), .MMIO_BASE(32'h0000_8000), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_we(in_we),
        .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_addr(out0_addr),
        .out0_wdata(out0_wdata), .out0_we(out0_we),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_addr(out1_addr),
        .out1_wdata(out1_wdata), .out1_we(out1_we),
        .misalign(misalign), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        lat;
        logic [31:0] cyc;
    } exp_t;

    exp_t exp0[$];
    exp_t exp1[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   mon_en = 1'b0;
    int   waited;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic pop_check(input int k, input logic [31:0] a, input logic [31:0] d, input logic w);
        exp_t e;
        if ((k == 0 && exp0.size() == 0) || (k == 1 && exp1.size() == 0)) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out%0d: got request addr %h, want no request", k, a);
            return;
        end
        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
        $display("[TB] port%0d handoff addr=%h wdata=%h we=%b", k, a, d, w);
        check($sformatf("out%0d_addr", k), a, e.addr);
        check($sformatf("out%0d_wdata", k), d, e.wdata);
        check($sformatf("out%0d_we", k), {31'd0, w}, {31'd0, e.we});
        if (e.lat) check($sformatf("out%0d_latency_cyc", k), cyc, e.cyc + 1);
    endtask

    task automatic monitor();
        logic        pv0 = 1'b0, pr0 = 1'b0, pw0 = 1'b0;
        logic        pv1 = 1'b0, pr1 = 1'b0, pw1 = 1'b0;
        logic        prst = 1'b1;
        logic [31:0] pa0 = '0, pd0 = '0, pa1 = '0, pd1 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && !rst && !prst) begin
                if (pv0 && !pr0) begin
                    check("hold0_valid", {31'd0, out0_valid}, 32'd1);
                    check("hold0_addr", out0_addr, pa0);
                    check("hold0_wdata", out0_wdata, pd0);
                    check("hold0_we", {31'd0, out0_we}, {31'd0, pw0});
                end
                if (pv1 && !pr1) begin
                    check("hold1_valid", {31'd0, out1_valid}, 32'd1);
                    check("hold1_addr", out1_addr, pa1);
                    check("hold1_wdata", out1_wdata, pd1);
                    check("hold1_we", {31'd0, out1_we}, {31'd0, pw1});
                end
            end
            if (mon_en && !rst) begin
                if (out0_valid && out0_ready) pop_check(0, out0_addr, out0_wdata, out0_we);
                if (out1_valid && out1_ready) pop_check(1, out1_addr, out1_wdata, out1_we);
            end
            pv0 = out0_valid; pr0 = out0_ready; pa0 = out0_addr; pd0 = out0_wdata; pw0 = out0_we;
            pv1 = out1_valid; pr1 = out1_ready; pa1 = out1_addr; pd1 = out1_wdata; pw1 = out1_we;
            prst = rst;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        idle(1);
        rst = 1'b0;
        exp0.delete();
        exp1.delete();
    endtask

    // Holds the request until accepted; 'port' is the hand-computed destination.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic w,
                        input int port, input bit lat, output int n);
        exp_t e;
        in_valid = 1'b1;
        in_addr  = a;
        in_wdata = d;
        in_we    = w;
        n = 0;
        sample();
        while (!in_ready && n < 40) begin
            sample();
            n++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready=%b after %0d cycles, want 1 (addr %h)", in_ready, n, a);
        end else begin
            e = '{addr: a, wdata: d, we: w, lat: lat, cyc: cyc};
            if (port == 0) exp0.push_back(e);
            else           exp1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_addr = 32'h10; in_wdata = 32'h55; in_we = 1'b1;
        out0_ready = 1'b1; out1_ready = 1'b1;
        fork
            monitor();
        join_none
        idle(1);
        mon_en = 1'b1;

        // Reset held for two edges with a pending request
        for (int i = 0; i < 2; i++) begin
            sample();
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_out0_valid", {31'd0, out0_valid}, 32'd0);
            check("rst_out1_valid", {31'd0, out1_valid}, 32'd0);
            check("rst_cnt0", {28'd0, cnt0}, 32'd0);
            check("rst_cnt1", {28'd0, cnt1}, 32'd0);
            check("rst_misalign", {31'd0, misalign}, 32'd0);
            if (i == 0) idle(1);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(32'h10, 32'h55, 1'b1, 0, 1'b1, waited);
        check("first_accept_wait", waited, 0);
        idle(3);
        check("first_cnt0", {28'd0, cnt0}, 32'd1);

        // Port 0 streaming
        do_reset();
        for (int i = 0; i < 4; i++) send(32'(i * 4), 32'hA0 + 32'(i), 1'b1, 0, 1'b1, waited);
        idle(3);
        check("stream_cnt0", {28'd0, cnt0}, 32'd4);
        check("stream_cnt1", {28'd0, cnt1}, 32'd0);

        // Backpressure on port 1 blocks a following port 0 request
        do_reset();
        out1_ready = 1'b0;
        send(32'h8000, 32'hB0, 1'b1, 1, 1'b0, waited);
        in_valid = 1'b1; in_addr = 32'h100; in_wdata = 32'hB1; in_we = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sample();
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out1_addr", out1_addr, 32'h8000);
            idle(1);
        end
        out1_ready = 1'b1;
        send(32'h100, 32'hB1, 1'b0, 0, 1'b1, waited);
        check("bp_cross_wait", waited, 0);
        idle(3);
        check("bp_cnt0", {28'd0, cnt0}, 32'd1);
        check("bp_cnt1", {28'd0, cnt1}, 32'd1);

        // Address boundaries
        do_reset();
        send(32'h0000_7FFC, 32'hD0, 1'b1, 0, 1'b1, waited);
        send(32'h0000_8000, 32'hD1, 1'b0, 1, 1'b1, waited);
        send(32'hFFFF_FFFC, 32'hD2, 1'b1, 1, 1'b1, waited);
        idle(3);
        check("bound_cnt0", {28'd0, cnt0}, 32'd1);
        check("bound_cnt1", {28'd0, cnt1}, 32'd2);
        check("bound_misalign", {31'd0, misalign}, 32'd0);

        // Misalign and counter saturation
        do_reset();
        check("sat_misalign_pre", {31'd0, misalign}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            send(32'h2, 32'(i), 1'b0, 0, 1'b1, waited);
            if (i == 0)  check("sat_misalign_first", {31'd0, misalign}, 32'd1);
            if (i == 13) check("sat_cnt0_14", {28'd0, cnt0}, 32'd14);
        end
        idle(3);
        check("sat_cnt0", {28'd0, cnt0}, 32'd15);
        check("sat_misalign", {31'd0, misalign}, 32'd1);

        // Reset during a port 1 stall
        do_reset();
        out1_ready = 1'b0;
        send(32'h9000, 32'hC0, 1'b1, 1, 1'b0, waited);
        sample();
        check("stall_out1_valid", {31'd0, out1_valid}, 32'd1);
        idle(1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        exp1.delete();
        out1_ready = 1'b1;
        sample();
        check("rstmid_out1_valid", {31'd0, out1_valid}, 32'd0);
        check("rstmid_cnt1", {28'd0, cnt1}, 32'd0);
        check("rstmid_cnt0", {28'd0, cnt0}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            sample();
            check("rstmid_quiet_out0", {31'd0, out0_valid}, 32'd0);
            check("rstmid_quiet_out1", {31'd0, out1_valid}, 32'd0);
        end

        check("end_queue0_left", exp0.size(), 0);
        check("end_queue1_left", exp1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end
endmodule
